// File: rtl/pipeline_ctrl_pkg.sv
// Shared types for the pipeline hazard / stall / flush controller.
package pipeline_ctrl_pkg;

  // Data-memory handshake FSM states (plain constants for legacy tools)
  typedef logic [0:0] dmem_state_t;
  localparam dmem_state_t StIdle = 1'b0;
  localparam dmem_state_t StWait = 1'b1;

  // Per-stage-register control bundle
  typedef struct packed {
    logic pc_write;
    logic hold_id;
    logic hold_ex;
    logic hold_mem;
    logic hold_wb;
    logic clear_id;
    logic clear_ex;
    logic clear_mem;
    logic clear_wb;
  } pipe_ctrl_t;

  // Operand forwarding source select
  typedef enum logic [1:0] {
    FwdRf  = 2'b00,
    FwdWb  = 2'b01,
    FwdMem = 2'b10
  } fwd_sel_t;

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Datapath <-> hazard controller signal bundle.
// FORWARDING_EN adds the forwarding select outputs and their source fields.
interface pipeline_ctrl_if;
  import pipeline_ctrl_pkg::*;

  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic        id_use_rs1;
  logic        id_use_rs2;
  logic [4:0]  ex_rd;
  logic        ex_RegWrite;
  logic        ex_MemRead;
  logic [4:0]  mem_rd;
  logic        mem_RegWrite;
  logic        mem_MemRead;
  logic        mem_MemWrite;
  logic        mem_branch_taken;
  logic        dmem_ready;
  logic        dmem_req;
  logic        pc_write;
  logic        hold_id;
  logic        hold_ex;
  logic        hold_mem;
  logic        hold_wb;
  logic        clear_id;
  logic        clear_ex;
  logic        clear_mem;
  logic        clear_wb;
  logic [15:0] stall_cycles;
`ifdef FORWARDING_EN
  logic [4:0]  wb_rd;
  logic        wb_RegWrite;
  logic [4:0]  ex_rs1;
  logic [4:0]  ex_rs2;
  fwd_sel_t    fwd_a;
  fwd_sel_t    fwd_b;
`endif

  // Datapath side
  modport master (
    output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_RegWrite, ex_MemRead,
    output mem_rd, mem_RegWrite, mem_MemRead, mem_MemWrite, mem_branch_taken, dmem_ready,
`ifdef FORWARDING_EN
    output wb_rd, wb_RegWrite, ex_rs1, ex_rs2,
    input  fwd_a, fwd_b,
`endif
    input  dmem_req, pc_write, hold_id, hold_ex, hold_mem, hold_wb,
    input  clear_id, clear_ex, clear_mem, clear_wb, stall_cycles
  );

  // Controller side
  modport slave (
    input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_RegWrite, ex_MemRead,
    input  mem_rd, mem_RegWrite, mem_MemRead, mem_MemWrite, mem_branch_taken, dmem_ready,
`ifdef FORWARDING_EN
    input  wb_rd, wb_RegWrite, ex_rs1, ex_rs2,
    output fwd_a, fwd_b,
`endif
    output dmem_req, pc_write, hold_id, hold_ex, hold_mem, hold_wb,
    output clear_id, clear_ex, clear_mem, clear_wb, stall_cycles
  );

endinterface

// File: rtl/pipeline_ctrl_dmem_fsm.sv
// Data-memory handshake sequencer: request strobe and stall generation.
module pipeline_ctrl_dmem_fsm
  import pipeline_ctrl_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic mem_access,
  input  logic dmem_ready,
  output logic dmem_req,
  output logic dmem_stall
);

  dmem_state_t state_q, state_d;

  // Request/stall decode and next state; WAIT keeps the request up regardless of MEM bits
  always_comb begin
    dmem_req   = 1'b0;
    dmem_stall = 1'b0;
    state_d    = state_q;
    if (!rst_n) begin
      state_d = StIdle;
    end else if (state_q == StIdle) begin
      dmem_req   = mem_access;
      dmem_stall = mem_access & ~dmem_ready;
      if (dmem_stall) state_d = StWait;
    end else begin
      dmem_req   = 1'b1;
      dmem_stall = ~dmem_ready;
      if (dmem_ready) state_d = StIdle;
    end
  end

  // State register, synchronous reset abandons any pending access
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Hazard and stall/flush controller for the 5-stage pipeline.
// Optional feature macro: FORWARDING_EN (operand forwarding, stalls only for load-use/dmem).
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  pipeline_ctrl_if.slave  bus
);

  pipe_ctrl_t  ctrl;
  logic        dmem_req;
  logic        dmem_stall;
  logic        rs1_hit_ex, rs2_hit_ex;
  logic        load_use;
  logic        data_hazard;
  logic [15:0] stall_cnt_q;

  pipeline_ctrl_dmem_fsm u_dmem_fsm (
    .clk        (clk),
    .rst_n      (rst_n),
    .mem_access (bus.mem_MemRead | bus.mem_MemWrite),
    .dmem_ready (bus.dmem_ready),
    .dmem_req   (dmem_req),
    .dmem_stall (dmem_stall)
  );

  assign rs1_hit_ex = bus.id_use_rs1 && (bus.id_rs1 == bus.ex_rd);
  assign rs2_hit_ex = bus.id_use_rs2 && (bus.id_rs2 == bus.ex_rd);
  assign load_use   = bus.ex_MemRead && (bus.ex_rd != 5'd0) && (rs1_hit_ex || rs2_hit_ex);

`ifdef FORWARDING_EN
  // Forward select for an EX operand; MEM result is newer than WB so it wins
  function automatic fwd_sel_t fwd_pick(input logic [4:0] rs, input logic mem_wr,
                                        input logic [4:0] mem_rd, input logic wb_wr,
                                        input logic [4:0] wb_rd);
    if (mem_wr && mem_rd != 5'd0 && mem_rd == rs)    return FwdMem;
    else if (wb_wr && wb_rd != 5'd0 && wb_rd == rs) return FwdWb;
    else                                             return FwdRf;
  endfunction

  assign bus.fwd_a = fwd_pick(bus.ex_rs1, bus.mem_RegWrite, bus.mem_rd,
                              bus.wb_RegWrite, bus.wb_rd);
  assign bus.fwd_b = fwd_pick(bus.ex_rs2, bus.mem_RegWrite, bus.mem_rd,
                              bus.wb_RegWrite, bus.wb_rd);
  assign data_hazard = load_use;
`else
  logic raw_ex, raw_mem;
  // Without forwarding every in-flight producer must drain past MEM first
  assign raw_ex  = bus.ex_RegWrite && (bus.ex_rd != 5'd0) && (rs1_hit_ex || rs2_hit_ex);
  assign raw_mem = bus.mem_RegWrite && (bus.mem_rd != 5'd0) &&
                   ((bus.id_use_rs1 && bus.id_rs1 == bus.mem_rd) ||
                    (bus.id_use_rs2 && bus.id_rs2 == bus.mem_rd));
  assign data_hazard = load_use || raw_ex || raw_mem;
`endif

  // Prioritised control: reset, dmem stall, branch flush, data hazard
  always_comb begin
    ctrl          = '0;
    ctrl.pc_write = 1'b1;
    if (!rst_n) begin
      ctrl.clear_id  = 1'b1;
      ctrl.clear_ex  = 1'b1;
      ctrl.clear_mem = 1'b1;
      ctrl.clear_wb  = 1'b1;
    end else if (dmem_stall) begin
      ctrl.pc_write = 1'b0;
      ctrl.hold_id  = 1'b1;
      ctrl.hold_ex  = 1'b1;
      ctrl.hold_mem = 1'b1;
      ctrl.clear_wb = 1'b1;
    end else if (bus.mem_branch_taken) begin
      // Dependent instruction in ID is squashed, so no load-use hold
      ctrl.clear_id  = 1'b1;
      ctrl.clear_ex  = 1'b1;
      ctrl.clear_mem = 1'b1;
    end else if (data_hazard) begin
      ctrl.pc_write = 1'b0;
      ctrl.hold_id  = 1'b1;
      ctrl.clear_ex = 1'b1;
    end
  end

  // Saturating count of cycles in which the PC was held
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt_q <= 16'd0;
    end else if (!ctrl.pc_write && stall_cnt_q != 16'hFFFF) begin
      stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign bus.dmem_req     = dmem_req;
  assign bus.pc_write     = ctrl.pc_write;
  assign bus.hold_id      = ctrl.hold_id;
  assign bus.hold_ex      = ctrl.hold_ex;
  assign bus.hold_mem     = ctrl.hold_mem;
  assign bus.hold_wb      = ctrl.hold_wb;
  assign bus.clear_id     = ctrl.clear_id;
  assign bus.clear_ex     = ctrl.clear_ex;
  assign bus.clear_mem    = ctrl.clear_mem;
  assign bus.clear_wb     = ctrl.clear_wb;
  assign bus.stall_cycles = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed self-checking bench for pipeline_ctrl.
// Control vector order: {pc_write, hold_id, hold_ex, hold_mem, hold_wb,
//                        clear_id, clear_ex, clear_mem, clear_wb}
module tb_pipeline_ctrl;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;
  int   exp_stall;
  int   req_cnt, stl_cnt, cwb_cnt;

  pipeline_ctrl_if bus ();

  pipeline_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [8:0] CtlReset  = 9'b1_0000_1111;
  localparam logic [8:0] CtlRun    = 9'b1_0000_0000;
  localparam logic [8:0] CtlDmem   = 9'b0_1110_0001;
  localparam logic [8:0] CtlHazard = 9'b0_1000_0100;
  localparam logic [8:0] CtlFlush  = 9'b1_0000_1110;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [8:0] ctrl_vec();
    return {bus.pc_write, bus.hold_id, bus.hold_ex, bus.hold_mem, bus.hold_wb,
            bus.clear_id, bus.clear_ex, bus.clear_mem, bus.clear_wb};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.id_rs1 = '0; bus.id_rs2 = '0; bus.id_use_rs1 = 0; bus.id_use_rs2 = 0;
    bus.ex_rd = '0; bus.ex_RegWrite = 0; bus.ex_MemRead = 0;
    bus.mem_rd = '0; bus.mem_RegWrite = 0; bus.mem_MemRead = 0; bus.mem_MemWrite = 0;
    bus.mem_branch_taken = 0; bus.dmem_ready = 0;
`ifdef FORWARDING_EN
    bus.wb_rd = '0; bus.wb_RegWrite = 0; bus.ex_rs1 = '0; bus.ex_rs2 = '0;
`endif
  endtask

  task automatic set_load_use();
    bus.ex_MemRead = 1; bus.ex_RegWrite = 1; bus.ex_rd = 5'd5;
    bus.id_rs1 = 5'd5; bus.id_use_rs1 = 1;
  endtask

  initial begin
    n_checks = 0; n_errors = 0; exp_stall = 0;
    clear_inputs();

    // Reset with a pending load: outputs forced regardless of inputs
    rst_n = 0;
    bus.mem_MemRead = 1;
    tick(); tick();
    check_eq("rst_dmem_req", {31'b0, bus.dmem_req}, 0);
    check_eq("rst_ctrl", {23'b0, ctrl_vec()}, {23'b0, CtlReset});
    check_eq("rst_stall_cnt", {16'b0, bus.stall_cycles}, 0);
    bus.mem_MemRead = 0;
    rst_n = 1;
    #1;
    check_eq("idle_ctrl", {23'b0, ctrl_vec()}, {23'b0, CtlRun});
    check_eq("idle_req", {31'b0, bus.dmem_req}, 0);
    tick();
    check_eq("idle_stall_cnt", {16'b0, bus.stall_cycles}, 0);

    // Load with ready arriving after 3 cycles
    req_cnt = 0; stl_cnt = 0; cwb_cnt = 0;
    bus.mem_MemRead = 1;
    for (int i = 0; i < 4; i++) begin
      bus.dmem_ready = (i == 3);
      #1;
      if (i == 0) check_eq("dmem_first_ctrl", {23'b0, ctrl_vec()}, {23'b0, CtlDmem});
      req_cnt += int'(bus.dmem_req);
      stl_cnt += int'(!bus.pc_write);
      cwb_cnt += int'(bus.clear_wb);
      tick();
    end
    clear_inputs();
    #1;
    exp_stall += 3;
    check_eq("dmem_req_cycles", req_cnt, 4);
    check_eq("dmem_stall_cycles", stl_cnt, 3);
    check_eq("dmem_clear_wb_cycles", cwb_cnt, 3);
    check_eq("dmem_stall_cnt", {16'b0, bus.stall_cycles}, exp_stall);
    check_eq("dmem_req_drop", {31'b0, bus.dmem_req}, 0);

    // WAIT keeps requesting after the MEM control bits vanish
    bus.mem_MemRead = 1;
    #1;
    tick();
    bus.mem_MemRead = 0;
    #1;
    check_eq("wait_req_held", {31'b0, bus.dmem_req}, 1);
    check_eq("wait_pc_hold", {31'b0, bus.pc_write}, 0);
    tick();
    bus.dmem_ready = 1;
    #1;
    check_eq("wait_ready_req", {31'b0, bus.dmem_req}, 1);
    check_eq("wait_ready_ctrl", {23'b0, ctrl_vec()}, {23'b0, CtlRun});
    tick();
    bus.dmem_ready = 0;
    #1;
    exp_stall += 2;
    check_eq("wait_exit_req", {31'b0, bus.dmem_req}, 0);
    check_eq("wait_stall_cnt", {16'b0, bus.stall_cycles}, exp_stall);

    // Zero-latency access
    bus.mem_MemWrite = 1; bus.dmem_ready = 1;
    #1;
    check_eq("fast_req", {31'b0, bus.dmem_req}, 1);
    check_eq("fast_ctrl", {23'b0, ctrl_vec()}, {23'b0, CtlRun});
    tick();
    clear_inputs();
    #1;
    check_eq("fast_stall_cnt", {16'b0, bus.stall_cycles}, exp_stall);

    // Load-use on rs1: one bubble
    set_load_use();
    #1;
    check_eq("lu_ctrl", {23'b0, ctrl_vec()}, {23'b0, CtlHazard});
    tick();
    exp_stall += 1;
    clear_inputs();
    #1;
    check_eq("lu_release", {23'b0, ctrl_vec()}, {23'b0, CtlRun});
    check_eq("lu_stall_cnt", {16'b0, bus.stall_cycles}, exp_stall);
    // x0 destination never hazards
    bus.ex_MemRead = 1; bus.ex_RegWrite = 1; bus.id_use_rs1 = 1;
    #1;
    check_eq("lu_x0", {23'b0, ctrl_vec()}, {23'b0, CtlRun});
    // rs2 match, and the same match when rs2 is not read
    bus.ex_rd = 5'd9; bus.id_rs2 = 5'd9; bus.id_use_rs2 = 1; bus.id_use_rs1 = 0;
    #1;
    check_eq("lu_rs2", {23'b0, ctrl_vec()}, {23'b0, CtlHazard});
    bus.id_use_rs2 = 0;
    #1;
    check_eq("lu_rs2_unused", {23'b0, ctrl_vec()}, {23'b0, CtlRun});
    clear_inputs();

    // Branch flush beats load-use
    set_load_use();
    bus.mem_branch_taken = 1;
    #1;
    check_eq("br_over_lu", {23'b0, ctrl_vec()}, {23'b0, CtlFlush});
    tick();
    clear_inputs();
    #1;
    check_eq("br_stall_cnt", {16'b0, bus.stall_cycles}, exp_stall);

    // Dmem stall beats branch flush
    bus.mem_MemRead = 1; bus.mem_branch_taken = 1;
    #1;
    check_eq("dmem_over_br", {23'b0, ctrl_vec()}, {23'b0, CtlDmem});
    tick();
    exp_stall += 1;
    bus.dmem_ready = 1;
    #1;
    check_eq("br_after_ready", {23'b0, ctrl_vec()}, {23'b0, CtlFlush});
    tick();
    clear_inputs();
    #1;

`ifdef FORWARDING_EN
    bus.mem_RegWrite = 1; bus.mem_rd = 5'd7; bus.ex_rs1 = 5'd7;
    bus.wb_RegWrite = 1; bus.wb_rd = 5'd7; bus.ex_rs2 = 5'd7;
    bus.id_rs1 = 5'd7; bus.id_use_rs1 = 1;
    #1;
    check_eq("fwd_a_mem", {30'b0, bus.fwd_a}, 2);
    check_eq("fwd_no_stall", {23'b0, ctrl_vec()}, {23'b0, CtlRun});
    bus.mem_RegWrite = 0;
    #1;
    check_eq("fwd_b_wb", {30'b0, bus.fwd_b}, 1);
    bus.wb_rd = 5'd0;
    #1;
    check_eq("fwd_a_x0", {30'b0, bus.fwd_a}, 0);
    clear_inputs();
`else
    // RAW against MEM stalls every cycle until the producer leaves
    bus.mem_RegWrite = 1; bus.mem_rd = 5'd7; bus.id_rs2 = 5'd7; bus.id_use_rs2 = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check_eq("raw_mem_stall", {23'b0, ctrl_vec()}, {23'b0, CtlHazard});
      tick();
    end
    exp_stall += 3;
    bus.mem_RegWrite = 0;
    #1;
    check_eq("raw_mem_release", {23'b0, ctrl_vec()}, {23'b0, CtlRun});
    check_eq("raw_stall_cnt", {16'b0, bus.stall_cycles}, exp_stall);
    clear_inputs();
    bus.ex_RegWrite = 1; bus.ex_rd = 5'd3; bus.id_rs1 = 5'd3; bus.id_use_rs1 = 1;
    #1;
    check_eq("raw_ex_stall", {23'b0, ctrl_vec()}, {23'b0, CtlHazard});
    clear_inputs();
    bus.mem_RegWrite = 1; bus.id_use_rs1 = 1;
    #1;
    check_eq("raw_mem_x0", {23'b0, ctrl_vec()}, {23'b0, CtlRun});
    clear_inputs();
`endif

    // Saturation of the stall counter
    set_load_use();
    #1;
    repeat (65534 - exp_stall) @(posedge clk);
    #1;
    check_eq("sat_fffe", {16'b0, bus.stall_cycles}, 32'hFFFE);
    tick();
    check_eq("sat_ffff", {16'b0, bus.stall_cycles}, 32'hFFFF);
    repeat (5000) @(posedge clk);
    #1;
    check_eq("sat_hold", {16'b0, bus.stall_cycles}, 32'hFFFF);
    clear_inputs();

    // Reset clears the counter and abandons a waiting access
    rst_n = 0;
    tick();
    rst_n = 1;
    #1;
    check_eq("rst_cnt_clear", {16'b0, bus.stall_cycles}, 0);
    bus.mem_MemRead = 1;
    #1;
    tick();
    rst_n = 0;
    #1;
    check_eq("rst_wait_req", {31'b0, bus.dmem_req}, 0);
    check_eq("rst_wait_ctrl", {23'b0, ctrl_vec()}, {23'b0, CtlReset});
    tick();
    bus.mem_MemRead = 0;
    rst_n = 1;
    #1;
    check_eq("rst_wait_idle_req", {31'b0, bus.dmem_req}, 0);
    check_eq("rst_wait_idle_ctrl", {23'b0, ctrl_vec()}, {23'b0, CtlRun});

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
